// File: rtl/dcm_rate_decoder.sv
// dcm_rate_decoder: measures the period of a divided clock sampled as data and
// decodes it back to the 3-bit program code that produced it.
module dcm_rate_decoder #(
  parameter int unsigned COUNT_10 = 5_000_000,
  parameter int unsigned TOL      = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clk_in,
  output logic [2:0]       prog_detected,
  output logic             detect_valid,
  output logic             detect_error,
  output logic             timeout,
  output logic             lock,
  output logic [CNT_W-1:0] period
);
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DECIDE} state_t;
  localparam logic [7:0][7:0] MULT = {8'd128, 8'd64, 8'd32, 8'd16, 8'd10, 8'd4, 8'd2, 8'd1};
  localparam logic [63:0] P7 = 64'd2 * (64'(COUNT_10) * 64'd128 + 64'd1);
  localparam logic [63:0] TMO_W = P7 + 64'(TOL) + 64'd1;
  localparam logic [CNT_W-1:0] TMO = TMO_W[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t           state_q;
  logic             s1_q, s2_q, s3_q, rise_q;
  logic [CNT_W-1:0] cnt_q, period_q;
  logic [2:0]       prog_q, code;
  logic             valid_q, error_q, timeout_q, lock_q, last_ok_q;
  logic [7:0]       match;
  // Expected periods are elaborated constants; only the compares are hardware.
  for (genvar k = 0; k < 8; k++) begin : g_cmp
    localparam logic [63:0] PW = 64'd2 * (64'(COUNT_10) * 64'(MULT[k]) + 64'd1);
    localparam logic [CNT_W-1:0] PK = PW[CNT_W-1:0];
    logic [CNT_W-1:0] diff;
    assign diff = (period_q >= PK) ? period_q - PK : PK - period_q;
    assign match[k] = diff <= CNT_W'(TOL);
  end
  always_comb begin
    code = 3'd0;
    for (int i = 7; i >= 0; i--) code = match[i] ? 3'(i) : code;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {s1_q, s2_q, s3_q, rise_q} <= '0;
    end else begin
      s1_q   <= clk_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      prog_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      lock_q    <= 1'b0;
      last_ok_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        lock_q    <= 1'b0;
        timeout_q <= 1'b0;
        last_ok_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= WAIT_EDGE;
          WAIT_EDGE: begin
            cnt_q   <= rise_q ? ONE : cnt_q;
            state_q <= rise_q ? MEASURE : WAIT_EDGE;
          end
          MEASURE: begin
            if (rise_q) begin
              period_q <= cnt_q;
              cnt_q    <= ONE;
              state_q  <= DECIDE;
            end else if (cnt_q >= TMO) begin
              error_q   <= 1'b1;
              timeout_q <= 1'b1;
              lock_q    <= 1'b0;
              last_ok_q <= 1'b0;
              state_q   <= WAIT_EDGE;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          DECIDE: begin
            // A rise here is only possible for illegal periods; treat it as a new closing edge.
            cnt_q    <= rise_q ? ONE : cnt_q + ONE;
            period_q <= rise_q ? cnt_q : period_q;
            state_q  <= rise_q ? DECIDE : MEASURE;
            if (|match) begin
              prog_q    <= code;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              lock_q    <= last_ok_q && (code == prog_q);
              last_ok_q <= 1'b1;
            end else begin
              error_q   <= 1'b1;
              lock_q    <= 1'b0;
              last_ok_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign prog_detected = prog_q;
  assign detect_valid  = valid_q;
  assign detect_error  = error_q;
  assign timeout       = timeout_q;
  assign lock          = lock_q;
  assign period        = period_q;
endmodule

// File: tb/tb_dcm_rate_decoder.sv
// tb_dcm_rate_decoder: directed and random periods checked against a
// rise-to-rise period model of the decoder.
module tb_dcm_rate_decoder;
  localparam int C10 = 10;
  localparam int TOL = 1;
  localparam int W   = 32;
  localparam int TMO = 2 * (C10 * 128 + 1) + TOL + 1;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, clk_in = 1'b0;
  logic [2:0]   prog_detected;
  logic         detect_valid, detect_error, timeout, lock;
  logic [W-1:0] period;
  int n_chk = 0, n_fail = 0, n_vp = 0, n_ep = 0;
  int mult [8] = '{1, 2, 4, 10, 16, 32, 64, 128};
  logic [38:0] exp_q[$];
  int cyc = 0, last_rise = 0, m_prog = 0, m_per = 0;
  bit armed = 0, m_en = 0, m_pv = 0, m_to = 0, m_lk = 0;
  logic prev_in = 1'b0;

  dcm_rate_decoder #(.COUNT_10(C10), .TOL(TOL), .CNT_W(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clk_in(clk_in),
    .prog_detected(prog_detected), .detect_valid(detect_valid),
    .detect_error(detect_error), .timeout(timeout), .lock(lock), .period(period)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] pack(input bit v, input int prog, input bit lk, input bit to, input int per);
    return {v, !v, 3'(prog), lk, to, 32'(per)};
  endfunction

  function automatic int ref_code(input int p);
    for (int k = 0; k < 8; k++) begin
      int pk;
      pk = 2 * (C10 * mult[k] + 1);
      if (p >= pk - TOL && p <= pk + TOL) return k;
    end
    return -1;
  endfunction

  task automatic on_close(input int p);
    int c;
    c = ref_code(p);
    m_per = p;
    if (c >= 0) begin
      m_lk = m_pv && (c == m_prog);
      m_prog = c;
      m_pv = 1;
      m_to = 0;
    end else begin
      m_lk = 0;
      m_pv = 0;
    end
    exp_q.push_back(pack(c >= 0, m_prog, m_lk, m_to, m_per));
  endtask

  task automatic step(input logic v);
    @(negedge clock);
    cyc++;
    clk_in = v;
    if (m_en && v && !prev_in) begin
      if (armed) on_close(cyc - last_rise);
      armed = 1;
      last_rise = cyc;
    end else if (armed && cyc - last_rise == TMO + 1) begin
      armed = 0;
      m_lk = 0;
      m_pv = 0;
      m_to = 1;
      exp_q.push_back(pack(0, m_prog, 0, 1, m_per));
    end
    prev_in = v;
  endtask

  task automatic hold(input int n, input logic v);
    repeat (n) step(v);
  endtask

  task automatic square(input int p, input int n);
    repeat (n) begin
      hold(p / 2, 1'b1);
      hold(p - p / 2, 1'b0);
    end
  endtask

  task automatic levels(input string tag);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_prog"}, prog_detected, m_prog);
    chk({tag, "_lock"}, lock, m_lk);
    chk({tag, "_tmo"}, timeout, m_to);
    chk({tag, "_per"}, period, m_per);
  endtask

  always @(negedge clock)
    if (detect_valid || detect_error) begin
      n_vp += int'(detect_valid);
      n_ep += int'(detect_error);
      if (exp_q.size() == 0) chk("spurious_pulse", {detect_valid, detect_error}, 2'b00);
      else chk("event", {detect_valid, detect_error, prog_detected, lock, timeout, period}, exp_q.pop_front());
    end

  initial begin
    int e0, p, k, dev;
    repeat (5) step(~clk_in);
    chk("rst_outputs", {prog_detected, detect_valid, detect_error, timeout, lock, period}, 0);
    reset = 1'b1;
    repeat (10) step(~clk_in);
    chk("idle_outputs", {prog_detected, detect_valid, detect_error, timeout, lock, period}, 0);
    chk("idle_pulses", n_vp + n_ep, 0);
    hold(6, 1'b0);
    enable = 1'b1;
    m_en = 1;
    square(22, 2);
    levels("nom22a");
    chk("nom22a_prog0", prog_detected, 0);
    chk("nom22a_nolock", lock, 0);
    chk("nom22a_period", period, 22);
    square(22, 1);
    chk("nom22b_lock", lock, 1);
    square(202, 3);
    levels("nom202");
    chk("nom202_prog3", prog_detected, 3);
    chk("nom202_lock", lock, 1);
    square(23, 2);
    square(21, 2);
    levels("tol21");
    chk("tol21_prog0", prog_detected, 0);
    e0 = n_ep;
    square(24, 2);
    levels("tol24");
    chk("tol24_err", n_ep - e0, 1);
    chk("tol24_prog_held", prog_detected, 0);
    chk("tol24_nolock", lock, 0);
    chk("tol24_period", period, 24);
    square(42, 1);
    e0 = n_ep;
    square(42, 3);
    chk("rate42_prog1", prog_detected, 1);
    chk("rate42_lock", lock, 1);
    square(82, 2);
    levels("rate82a");
    chk("rate82a_prog2", prog_detected, 2);
    chk("rate82a_nolock", lock, 0);
    square(82, 2);
    chk("rate82b_lock", lock, 1);
    chk("rate_no_err", n_ep - e0, 0);
    square(22, 2);
    e0 = n_ep;
    hold(11, 1'b1);
    hold(2580, 1'b0);
    levels("tmo");
    chk("tmo_err", n_ep - e0, 1);
    chk("tmo_set", timeout, 1);
    chk("tmo_nolock", lock, 0);
    square(22, 2);
    levels("tmo_clear");
    chk("tmo_cleared", timeout, 0);
    square(642, 2);
    hold(321, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_rst_outputs", {prog_detected, detect_valid, detect_error, timeout, lock, period}, 0);
    chk("abort_rst_pending", exp_q.size(), 0);
    armed = 0; m_pv = 0; m_to = 0; m_lk = 0; m_prog = 0; m_per = 0;
    hold(5, 1'b0);
    reset = 1'b1;
    hold(5, 1'b0);
    levels("abort_rst");
    square(642, 2);
    square(642, 1);
    chk("abort_en_lock_before", lock, 1);
    hold(321, 1'b1);
    enable = 1'b0;
    m_en = 0; armed = 0; m_pv = 0; m_to = 0; m_lk = 0;
    hold(5, 1'b0);
    levels("abort_en");
    chk("abort_en_prog_held", prog_detected, 5);
    chk("abort_en_nolock", lock, 0);
    enable = 1'b1;
    m_en = 1;
    hold(2, 1'b0);
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 4));
      dev = int'($urandom_range(0, 4)) - 2;
      p = 2 * (C10 * mult[k] + 1) + dev;
      square(p, int'($urandom_range(1, 2)));
    end
    square(22, 1);
    levels("rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcm_rate_decoder.md
Name: dcm_rate_decoder

Overview:
- Receive-side companion to the programmable clock manager: samples a divided clock (clock_2-style output) as data on the system clock.
- Measures its full period in system cycles and decodes it back to the 3-bit program code that produced it.
- Flags lock, mismatch and timeout. Used for self-check of the clock manager and to recover the rate setting on a remote board.

Parameters:
- COUNT_10, 5_000_000, base half-period terminal count used by the clock manager; must match the transmitter.
- TOL, 4, allowed absolute deviation in system cycles between measured and expected period.
- CNT_W, 32, width of the period counter; must hold P(7)+TOL+2.

Ports:
- clock  input  1  system clock; same clock as the clock manager.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = measure; 0 = return to idle and clear lock.
- clk_in  input  1  monitored divided clock, asynchronous to clock; treated as data.
- prog_detected  output  3  last successfully decoded program code.
- detect_valid  output  1  one-cycle pulse when a measurement decodes successfully.
- detect_error  output  1  one-cycle pulse on an unmatched period or a timeout.
- timeout  output  1  level; set on timeout, cleared by the next valid decode or when enable=0.
- lock  output  1  level; two consecutive valid decodes with the same code.
- period  output  CNT_W  last measured period in cycles, updated on every closing edge.

Behaviour:
- Clock domain: one clock domain. Reset is asynchronous and active-low on port reset.
- Reset values: every output is 0; FSM = IDLE; synchronizer and counter are 0.
- Input path:
  - clk_in passes through a 2-FF synchronizer, then a registered rising-edge detector producing rise_p.
  - Latency from clk_in rise to rise_p is 3 cycles, constant, so it cancels in the period measurement.
- Expected periods:
  - P(k) = 2*(COUNT_10*M(k)+1), where M = {1,2,4,10,16,32,64,128} for k = 0..7.
  - These constants are elaborated at compile time with no runtime multiply.
- FSM:
  - IDLE: all pulses 0. Go to WAIT_EDGE when enable=1.
  - WAIT_EDGE: on rise_p, clear cnt to 1 and go to MEASURE.
  - MEASURE: cnt increments each cycle. On rise_p, latch period<=cnt, restart cnt at 1, go to DECIDE. The next period's measurement runs back-to-back with no lost edge.
  - MEASURE timeout: if cnt reaches P(7)+TOL+1 with no rise_p, pulse detect_error, set timeout=1, clear lock, go to WAIT_EDGE.
  - DECIDE (1 cycle, cnt keeps counting):
    - Compare period with P(k) for all k in parallel. A match is |period-P(k)| <= TOL. The lowest matching k wins.
    - On a match: prog_detected<=k, detect_valid=1, timeout<=0. lock<=1 if k equals the previous valid code and the previous measurement was valid, else lock<=0.
    - On no match: detect_error=1, prog_detected holds its value, lock<=0.
    - Return to MEASURE. A rise_p arriving while in DECIDE is not possible for legal periods; if it occurs, it is handled as the next closing edge.
- detect_valid and detect_error assert in the cycle after the closing rise_p. They are mutually exclusive.
- Period definition: rise_p at cycles t and t+P gives period = P.
- enable=0 in any state: next state IDLE; lock and timeout cleared; any measurement in progress is discarded with no pulse. prog_detected and period hold.
- Asynchronous reset mid-measurement: immediate return to reset values. The first edge after reset only starts a measurement and never produces a decode.
- Arithmetic: all comparisons are unsigned CNT_W-bit. Absolute difference is computed as a subtraction of the larger minus the smaller. The counter cannot overflow because of the timeout.

Test Plan:
Bench parameters: COUNT_10=10, TOL=1, so P = 22, 42, 82, 202, 322, 642, 1282, 2562.
- Reset/idle: hold reset=0 for 5 cycles with clk_in toggling, then release with enable=0. Required: all outputs stay 0 and no pulses appear.
- Nominal decode: clk_in square wave with period 22, enable=1. Required:
  - First closing edge gives period=22, detect_valid pulse, prog_detected=0, lock=0.
  - Second closing edge gives lock=1.
  - Repeat with period 202: prog_detected=3 and lock=1 after two periods.
- Tolerance boundary: periods of 23 and 21 decode to prog 0. A period of 24 gives a detect_error pulse, prog_detected held at its previous value, and lock=0.
- Rate change: 4 periods of 42, then 4 periods of 82. Required:
  - Code goes 1 -> 2.
  - lock drops to 0 on the first 82 period and returns to 1 on the second.
  - No error pulses.
- Timeout: one rise, then hold clk_in low. Required:
  - After 2564 cycles with no further rise: one detect_error pulse, timeout=1, lock=0.
  - Restoring a 22 period clears timeout on the first valid decode.
- Mid-operation abort: pull reset low halfway through a 642 period. Required: outputs go to 0 immediately and no pulse appears. Repeat using enable=0 instead of reset: lock=0, no pulse, and prog_detected is held.
